// File: rtl/sub_offset_cal.sv
// sub_offset_cal
//   Receive-side inverse of the offset-add stage. Unsigned offset-binary
//   fixed-point samples (width_H integer + width_W fraction bits) are turned
//   back into signed two's complement by subtracting an offset, with
//   saturation. The offset resets to const_num and can be re-measured on
//   demand by averaging 2**CAL_LOG2 incoming samples.
//
// Ports
//   clk        clock, all logic on rising edge
//   rst_n      synchronous active-low reset
//   cal_start  calibration request (level, sampled each cycle)
//   data_i_en  input sample valid
//   data_i     unsigned offset-binary sample, W = width_H + width_W bits
//   data_o_en  output sample valid, one cycle after data_i_en
//   data_o     signed, saturated result
//   offset_o   offset currently applied
//   cal_busy   high while calibration is accumulating
//   cal_done   one-cycle pulse when a new offset is loaded
module sub_offset_cal #(
  parameter int width_H   = 5,
  parameter int width_W   = 20,
  parameter int const_num = 65536,
  parameter int CAL_LOG2  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cal_start,
  input  logic                         data_i_en,
  input  logic [width_H+width_W-1:0]   data_i,
  output logic                         data_o_en,
  output logic [width_H+width_W-1:0]   data_o,
  output logic [width_H+width_W-1:0]   offset_o,
  output logic                         cal_busy,
  output logic                         cal_done
);

  localparam int W  = width_H + width_W;
  localparam int AW = W + CAL_LOG2;

  localparam logic [W-1:0] OFFSET_RST = W'(const_num);
  localparam logic [W-1:0] SAT_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN    = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {RUN, CAL} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       acc, acc_nxt, sum;
  logic [CAL_LOG2-1:0] cnt, cnt_nxt;
  logic [W-1:0]        offset_nxt;
  logic                busy_nxt, done_nxt;
  logic [W:0]          diff;
  logic [W-1:0]        sat;

  // Subtraction in W+1 bits; overflow into the signed W-bit range shows up
  // as the top two bits of the difference disagreeing.
  always_comb begin
    diff = {1'b0, data_i} - {1'b0, offset_o};
    if (diff[W] != diff[W-1])
      sat = diff[W] ? SAT_MIN : SAT_MAX;
    else
      sat = diff[W-1:0];
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    offset_nxt = offset_o;
    busy_nxt   = cal_busy;
    done_nxt   = 1'b0;
    sum        = acc + AW'(data_i);
    case (state)
      RUN: begin
        if (cal_start) begin
          state_nxt = CAL;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      CAL: begin
        if (data_i_en) begin
          if (cnt == '1) begin
            // Average includes the completing sample; truncating divide.
            offset_nxt = sum[AW-1:CAL_LOG2];
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = RUN;
            acc_nxt    = '0;
            cnt_nxt    = '0;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + CAL_LOG2'(1);
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      acc       <= '0;
      cnt       <= '0;
      offset_o  <= OFFSET_RST;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      data_o_en <= 1'b0;
      data_o    <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      offset_o  <= offset_nxt;
      cal_busy  <= busy_nxt;
      cal_done  <= done_nxt;
      data_o_en <= data_i_en;
      if (data_i_en)
        data_o <= sat;
    end
  end

endmodule

// File: tb/tb_sub_offset_cal.sv
module tb_sub_offset_cal;

  localparam int W = 25;
  localparam logic [W-1:0] IN_MAX  = 25'h1FFFFFF;
  localparam logic [W-1:0] NEG_64K = 25'h1FF0000;
  localparam logic [W-1:0] OUT_MAX = 25'h0FFFFFF;
  localparam logic [W-1:0] OUT_MIN = 25'h1000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cal_start;
  logic         data_i_en;
  logic [W-1:0] data_i;
  logic         data_o_en;
  logic [W-1:0] data_o;
  logic [W-1:0] offset_o;
  logic         cal_busy;
  logic         cal_done;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  sub_offset_cal #(
    .width_H  (5),
    .width_W  (20),
    .const_num(65536),
    .CAL_LOG2 (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cal_start(cal_start),
    .data_i_en(data_i_en),
    .data_i   (data_i),
    .data_o_en(data_o_en),
    .data_o   (data_o),
    .offset_o (offset_o),
    .cal_busy (cal_busy),
    .cal_done (cal_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [W-1:0] d, input logic cs);
    data_i_en = en;
    data_i    = d;
    cal_start = cs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1 reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'($urandom), W'($urandom), 1'($urandom));
    chk("rst_data_o",    data_o, '0);
    chk("rst_data_o_en", W'(data_o_en), '0);
    chk("rst_offset",    offset_o, 25'd65536);
    chk("rst_busy",      W'(cal_busy), '0);
    chk("rst_done",      W'(cal_done), '0);
    rst_n = 1'b1;

    // T2 conversion
    step(1'b1, 25'd65636, 1'b0);
    chk("conv_pos_en", W'(data_o_en), 25'd1);
    chk("conv_pos",    data_o, 25'd100);
    step(1'b1, 25'd0, 1'b0);
    chk("conv_neg", data_o, NEG_64K);
    step(1'b0, 25'd12345, 1'b0);
    chk("gap_en",   W'(data_o_en), '0);
    chk("gap_hold", data_o, NEG_64K);
    step(1'b0, 25'd999, 1'b0);
    chk("gap_hold2", data_o, NEG_64K);

    // T3 positive saturation
    step(1'b1, IN_MAX, 1'b0);
    chk("sat_pos", data_o, OUT_MAX);

    // T4 calibration on 70000 with gaps
    step(1'b0, 25'd0, 1'b1);
    chk("cal_busy_start", W'(cal_busy), 25'd1);
    chk("cal_start_noen", W'(data_o_en), '0);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 2) begin
        step(1'b0, 25'd5, 1'b0);
        chk("cal_gap_en",   W'(data_o_en), '0);
        chk("cal_gap_busy", W'(cal_busy), 25'd1);
      end
      step(1'b1, 25'd70000, 1'b0);
      chk("cal_old_offset", data_o, 25'd4464);
      if (i < 15) begin
        chk("cal_busy_mid", W'(cal_busy), 25'd1);
        chk("cal_done_mid", W'(cal_done), '0);
      end
    end
    chk("cal_done",     W'(cal_done), 25'd1);
    chk("cal_busy_end", W'(cal_busy), '0);
    chk("cal_offset",   offset_o, 25'd70000);
    step(1'b1, 25'd70010, 1'b0);
    chk("cal_new_offset", data_o, 25'd10);
    chk("cal_done_pulse", W'(cal_done), '0);

    // T3 negative saturation: calibrate on full-scale samples
    step(1'b0, 25'd0, 1'b1);
    for (int i = 0; i < 16; i++)
      step(1'b1, IN_MAX, 1'b0);
    chk("maxcal_done",   W'(cal_done), 25'd1);
    chk("maxcal_offset", offset_o, IN_MAX);
    step(1'b1, 25'd0, 1'b0);
    chk("sat_neg", data_o, OUT_MIN);

    // T5 truncation, cal_start held throughout calibration
    step(1'b0, 25'd0, 1'b1);
    chk("trunc_busy", W'(cal_busy), 25'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < 8) ? 25'd3 : 25'd4, 1'b1);
      if (i == 0)
        chk("trunc_sat_conv", data_o, OUT_MIN);
      if (i < 15)
        chk("trunc_busy_mid", W'(cal_busy), 25'd1);
    end
    chk("trunc_done",   W'(cal_done), 25'd1);
    chk("trunc_offset", offset_o, 25'd3);
    // cal_start still high during the cal_done cycle -> new calibration
    step(1'b0, 25'd0, 1'b1);
    chk("restart_busy", W'(cal_busy), 25'd1);
    chk("restart_done", W'(cal_done), '0);

    // T6 abort by reset after 5 samples
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 25'd13, 1'b0);
      chk("abort_conv", data_o, 25'd10);
    end
    rst_n = 1'b0;
    step(1'b0, 25'd0, 1'b0);
    chk("abort_busy",   W'(cal_busy), '0);
    chk("abort_offset", offset_o, 25'd65536);
    chk("abort_done",   W'(cal_done), '0);
    chk("abort_data_o", data_o, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 25'd0, 1'b0);
      chk("post_abort_done", W'(cal_done), '0);
      chk("post_abort_busy", W'(cal_busy), '0);
    end
    step(1'b1, 25'd65636, 1'b0);
    chk("post_abort_conv", data_o, 25'd100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
